// File: rtl/aes_pkg.sv
// Shared types and widths for the AES-256 CTR keystream controller.
package aes_pkg;
  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 256;

  typedef enum logic [2:0] {
    S_NOKEY,
    S_KEYEXP,
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_HAVE
  } state_e;
endpackage

// File: rtl/aes_ctr_inc.sv
// Counter-block increment: only the low CTR_WIDTH bits count, the rest stay fixed.
module aes_ctr_inc
  import aes_pkg::*;
#(
  parameter int CTR_WIDTH = 128
) (
  input  logic [BLOCK_W-1:0] ctr_i,
  output logic [BLOCK_W-1:0] ctr_o,
  output logic               wrap_o
);
  logic [CTR_WIDTH-1:0] field;

  assign field  = ctr_i[CTR_WIDTH-1:0] + {{(CTR_WIDTH-1){1'b0}}, 1'b1};
  assign wrap_o = &ctr_i[CTR_WIDTH-1:0];

  if (CTR_WIDTH < BLOCK_W) begin : g_part
    assign ctr_o = {ctr_i[BLOCK_W-1:CTR_WIDTH], field};
  end else begin : g_full
    assign ctr_o = field;
  end
endmodule

// File: rtl/aes_ctr_keystream_ctrl.sv
// CTR-mode sequencer around the AES-256 core: key expansion, one-block keystream
// prefetch, and a valid/ready data path that XORs host blocks with keystream.
module aes_ctr_keystream_ctrl
  import aes_pkg::*;
#(
  parameter int CTR_WIDTH = 128
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic [KEY_W-1:0]   key_in,
  input  logic               key_load,
  output logic               key_ready,
  output logic               key_valid,
  input  logic [BLOCK_W-1:0] iv_in,
  input  logic               iv_load,
  output logic               iv_ready,
  input  logic [BLOCK_W-1:0] din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [BLOCK_W-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               ctr_wrap,
  output logic               core_start,
  output logic               core_key_start,
  output logic [KEY_W-1:0]   core_key,
  output logic [BLOCK_W-1:0] core_plaintext,
  input  logic [BLOCK_W-1:0] core_ciphertext,
  input  logic               core_finished,
  input  logic               core_key_finished
);
  state_e             state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [BLOCK_W-1:0] ctr_q, ctr_d, ctr_inc, ks_q, ks_d, dout_q, dout_d;
  logic               iv_set_q, iv_set_d, key_valid_q, key_valid_d;
  logic               ks_valid_q, ks_valid_d, dout_valid_q, dout_valid_d;
  logic               wrap_q, wrap_d, wrap_inc, key_start_q;
  logic               fin_q, kfin_q, fin_edge, kfin_edge;
  logic               key_acc, iv_acc, din_acc;

  aes_ctr_inc #(.CTR_WIDTH(CTR_WIDTH)) u_inc (
    .ctr_i  (ctr_q),
    .ctr_o  (ctr_inc),
    .wrap_o (wrap_inc)
  );

  assign fin_edge  = core_finished & ~fin_q;
  assign kfin_edge = core_key_finished & ~kfin_q;
  assign key_ready = (state_q != S_KEYEXP) && (state_q != S_WAIT);
  assign iv_ready  = (state_q == S_NOKEY) || (state_q == S_IDLE) || (state_q == S_HAVE);
  assign key_acc   = key_load & key_ready;
  assign iv_acc    = iv_load & iv_ready;
  // A same-cycle key or IV load wins over a data accept.
  assign din_ready = (state_q == S_HAVE) & ks_valid_q & (~dout_valid_q | dout_ready)
                     & ~iv_acc & ~key_acc;
  assign din_acc   = din_valid & din_ready;

  assign key_valid      = key_valid_q;
  assign dout           = dout_q;
  assign dout_valid     = dout_valid_q;
  assign ctr_wrap       = wrap_q;
  assign core_start     = (state_q == S_LAUNCH);
  assign core_key_start = key_start_q;
  assign core_key       = key_q;
  assign core_plaintext = ctr_q;

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    ctr_d        = ctr_q;
    ks_d         = ks_q;
    dout_d       = dout_q;
    iv_set_d     = iv_set_q;
    key_valid_d  = key_valid_q;
    ks_valid_d   = ks_valid_q;
    dout_valid_d = dout_valid_q;
    wrap_d       = wrap_q;

    case (state_q)
      S_NOKEY:  if (key_acc) state_d = S_KEYEXP;
      S_KEYEXP: if (kfin_edge) begin
        key_valid_d = 1'b1;
        state_d     = iv_set_q ? S_LAUNCH : S_IDLE;
      end
      S_IDLE: begin
        if (key_acc)     state_d = S_KEYEXP;
        else if (iv_acc) state_d = S_LAUNCH;
      end
      S_LAUNCH: state_d = key_acc ? S_KEYEXP : S_WAIT;
      S_WAIT: if (fin_edge) begin
        ks_d       = core_ciphertext;
        ks_valid_d = 1'b1;
        state_d    = S_HAVE;
      end
      S_HAVE: begin
        if (key_acc)                state_d = S_KEYEXP;
        else if (iv_acc || din_acc) state_d = S_LAUNCH;
      end
      default: state_d = S_NOKEY;
    endcase

    if (key_acc) begin
      key_d       = key_in;
      key_valid_d = 1'b0;
      ks_valid_d  = 1'b0;
    end
    if (iv_acc) begin
      ctr_d      = iv_in;
      iv_set_d   = 1'b1;
      wrap_d     = 1'b0;
      ks_valid_d = 1'b0;
    end
    if (din_acc) begin
      dout_d       = din ^ ks_q;
      dout_valid_d = 1'b1;
      ctr_d        = ctr_inc;
      wrap_d       = wrap_q | wrap_inc;
      ks_valid_d   = 1'b0;
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q      <= S_NOKEY;
      key_q        <= '0;
      ctr_q        <= '0;
      ks_q         <= '0;
      dout_q       <= '0;
      iv_set_q     <= 1'b0;
      key_valid_q  <= 1'b0;
      ks_valid_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      key_start_q  <= 1'b0;
      fin_q        <= 1'b0;
      kfin_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      ctr_q        <= ctr_d;
      ks_q         <= ks_d;
      dout_q       <= dout_d;
      iv_set_q     <= iv_set_d;
      key_valid_q  <= key_valid_d;
      ks_valid_q   <= ks_valid_d;
      dout_valid_q <= dout_valid_d;
      wrap_q       <= wrap_d;
      key_start_q  <= key_acc;
      fin_q        <= core_finished;
      kfin_q       <= core_key_finished;
    end
  end
endmodule

// File: tb/tb_aes_ctr_keystream_ctrl.sv
// Directed bench: behavioural AES core stand-ins, scoreboard of expected dout blocks.
module tb_aes_ctr_keystream_ctrl;
  localparam logic [255:0] NIST_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY2     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CTR1  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] CTR2  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] CTRW2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfe00;
  localparam logic [127:0] KS1   = 128'h0bdf7df1591716335e9a8b15c860c502;
  localparam logic [127:0] KS2   = 128'h5a6e699d536119065433863c8f657b94;
  localparam logic [127:0] DIN1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] DIN2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] DIN3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] DIN4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] DOUT1 = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] DOUT2 = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
  localparam int CORE_LAT = 6;
  localparam int W_KV = 0, W_DR = 1, W_BKV = 2, W_BDR = 3;

  logic CLK = 1'b0, RESETn = 1'b0;
  always #5 CLK = ~CLK;

  // DUT A: full 128-bit counter
  logic [255:0] key_in = '0, core_key;
  logic [127:0] iv_in = '0, din = '0, dout, core_plaintext, core_ciphertext = '0;
  logic key_load = 0, iv_load = 0, din_valid = 0, dout_ready = 0;
  logic key_ready, key_valid, iv_ready, din_ready, dout_valid, ctr_wrap, core_start, core_key_start;
  logic core_finished = 1'b0, core_key_finished = 1'b0;
  // DUT B: 8-bit counter field
  logic [255:0] b_key_in = '0, b_core_key;
  logic [127:0] b_iv_in = '0, b_din = '0, b_dout, b_core_plaintext, b_core_ciphertext = '0;
  logic b_key_load = 0, b_iv_load = 0, b_din_valid = 0, b_dout_ready = 0;
  logic b_key_ready, b_key_valid, b_iv_ready, b_din_ready, b_dout_valid, b_ctr_wrap, b_core_start, b_core_key_start;
  logic b_core_finished = 1'b0, b_core_key_finished = 1'b0;

  aes_ctr_keystream_ctrl #(.CTR_WIDTH(128)) dut_a (
    .CLK(CLK), .RESETn(RESETn), .key_in(key_in), .key_load(key_load), .key_ready(key_ready),
    .key_valid(key_valid), .iv_in(iv_in), .iv_load(iv_load), .iv_ready(iv_ready), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .ctr_wrap(ctr_wrap), .core_start(core_start),
    .core_key_start(core_key_start), .core_key(core_key), .core_plaintext(core_plaintext),
    .core_ciphertext(core_ciphertext), .core_finished(core_finished),
    .core_key_finished(core_key_finished));

  aes_ctr_keystream_ctrl #(.CTR_WIDTH(8)) dut_b (
    .CLK(CLK), .RESETn(RESETn), .key_in(b_key_in), .key_load(b_key_load), .key_ready(b_key_ready),
    .key_valid(b_key_valid), .iv_in(b_iv_in), .iv_load(b_iv_load), .iv_ready(b_iv_ready), .din(b_din),
    .din_valid(b_din_valid), .din_ready(b_din_ready), .dout(b_dout), .dout_valid(b_dout_valid),
    .dout_ready(b_dout_ready), .ctr_wrap(b_ctr_wrap), .core_start(b_core_start),
    .core_key_start(b_core_key_start), .core_key(b_core_key), .core_plaintext(b_core_plaintext),
    .core_ciphertext(b_core_ciphertext), .core_finished(b_core_finished),
    .core_key_finished(b_core_key_finished));

  // Keystream stand-in: real AES-256 values for the two NIST counter blocks, a fixed mix otherwise.
  function automatic logic [127:0] ks_fn(input logic [255:0] k, input logic [127:0] p);
    if (k == NIST_KEY && p == CTR1) return KS1;
    if (k == NIST_KEY && p == CTR2) return KS2;
    return p ^ k[127:0] ^ k[255:128] ^ 128'h0123456789abcdef_fedcba9876543210;
  endfunction

  int a_cnt = 0, a_kcnt = 0, a_launches = 0, b_cnt = 0, b_kcnt = 0;
  logic [127:0] a_pt = '0, b_pt = '0;
  always @(posedge CLK) begin
    if (core_key_start) begin core_key_finished <= 1'b0; a_kcnt <= CORE_LAT; end
    else if (a_kcnt > 0) begin a_kcnt <= a_kcnt - 1; if (a_kcnt == 1) core_key_finished <= 1'b1; end
    if (core_start) begin
      core_finished <= 1'b0; a_cnt <= CORE_LAT; a_pt <= core_plaintext; a_launches <= a_launches + 1;
    end else if (a_cnt > 0) begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1) begin core_finished <= 1'b1; core_ciphertext <= ks_fn(core_key, a_pt); end
    end
  end
  always @(posedge CLK) begin
    if (b_core_key_start) begin b_core_key_finished <= 1'b0; b_kcnt <= CORE_LAT; end
    else if (b_kcnt > 0) begin b_kcnt <= b_kcnt - 1; if (b_kcnt == 1) b_core_key_finished <= 1'b1; end
    if (b_core_start) begin
      b_core_finished <= 1'b0; b_cnt <= CORE_LAT; b_pt <= b_core_plaintext;
    end else if (b_cnt > 0) begin
      b_cnt <= b_cnt - 1;
      if (b_cnt == 1) begin b_core_finished <= 1'b1; b_core_ciphertext <= ks_fn(b_core_key, b_pt); end
    end
  end

  int total = 0, bad = 0;
  logic [127:0] exp_q[$];
  logic [255:0] key_m = '0;
  logic [127:0] ctr_m = '0;
  logic last_acc = 0, b_acc = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes just before the next edge, update the model, then advance one cycle.
  task automatic cyc();
    logic [127:0] e;
    #1;
    if (core_start) chk("launch_pt", core_plaintext, ctr_m);
    last_acc = din_valid && din_ready;
    b_acc    = b_din_valid && b_din_ready;
    if (dout_valid && dout_ready && RESETn) begin
      if (exp_q.size() == 0) chk("sb_unexpected", dout, '1);
      else begin e = exp_q.pop_front(); chk("sb_dout", dout, e); end
    end
    if (key_load && key_ready) key_m = key_in;
    if (iv_load && iv_ready) ctr_m = iv_in;
    else if (last_acc) begin exp_q.push_back(din ^ ks_fn(key_m, ctr_m)); ctr_m = ctr_m + 1; end
    if (!RESETn) begin ctr_m = '0; exp_q.delete(); end
    @(negedge CLK);
  endtask

  function automatic logic cond(input int which);
    case (which)
      W_KV:    return key_valid;
      W_DR:    return din_ready;
      W_BKV:   return b_key_valid;
      W_BDR:   return b_din_ready;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int which, input string tag);
    int n = 0;
    while (!cond(which) && n < 200) begin cyc(); n++; end
    chk(tag, {255'b0, cond(which)}, 256'd1);
  endtask

  task automatic send(input logic [127:0] d, input string tag);
    int n = 0;
    din = d; din_valid = 1'b1;
    do begin cyc(); n++; end while (!last_acc && n < 200);
    din_valid = 1'b0;
    chk(tag, {255'b0, last_acc}, 256'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_flags"}, {dout_valid, key_valid, din_ready, core_start, core_key_start, ctr_wrap,
                          key_ready, iv_ready}, 8'b0000_0011);
    chk({tag, "_dout"}, dout, '0);
    chk({tag, "_pt"}, core_plaintext, '0);
    chk({tag, "_key"}, core_key, '0);
    chk({tag, "_b_flags"}, {b_dout_valid, b_key_valid, b_din_ready, b_core_start, b_ctr_wrap},
        5'b0);
  endtask

  initial begin
    logic [127:0] exp3;
    int l0, n;
    @(negedge CLK);
    repeat (3) cyc();
    RESETn = 1'b1; dout_ready = 1'b1; b_dout_ready = 1'b1;
    chk_reset("rst");

    // key then IV
    key_in = NIST_KEY; key_load = 1'b1; cyc(); key_load = 1'b0;
    chk("key_start", {core_key_start, key_ready}, 2'b10);
    chk("core_key", core_key, NIST_KEY);
    cyc();
    chk("key_start_pulse", core_key_start, 0);
    wait_cond(W_KV, "to_key_valid");
    cyc();
    chk("idle_no_launch", core_start, 0);
    iv_in = CTR1; iv_load = 1'b1; cyc(); iv_load = 1'b0;
    chk("iv_launch", {core_start, core_plaintext}, {1'b1, CTR1});

    // two-block stream
    send(DIN1, "acc1");
    chk("dout1", {dout_valid, dout}, {1'b1, DOUT1});
    chk("launch2", {core_start, core_plaintext}, {1'b1, CTR2});
    send(DIN2, "acc2");
    chk("dout2", dout, DOUT2);
    repeat (2) cyc();

    // backpressure
    dout_ready = 1'b0;
    exp3 = DIN3 ^ ks_fn(key_m, ctr_m);
    send(DIN3, "acc3");
    l0 = a_launches;
    din = DIN4; din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("bp_dout", {dout_valid, dout}, {1'b1, exp3});
      if (i >= 14) chk("bp_din_ready", din_ready, 0);
      cyc();
    end
    chk("bp_launches", a_launches, l0 + 1);
    dout_ready = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!last_acc && n < 50);
    din_valid = 1'b0;
    chk("bp_acc4", last_acc, 1);

    // key reload in S_HAVE
    wait_cond(W_DR, "have_before_rekey");
    key_in = KEY2; key_load = 1'b1; cyc(); key_load = 1'b0;
    chk("rekey", {key_valid, din_ready, core_key_start}, 3'b001);
    wait_cond(W_KV, "rekey_valid");
    chk("relaunch", {core_start, core_plaintext}, {1'b1, ctr_m});
    send(DIN3 ^ DIN4, "acc5");

    // reset in the middle of S_WAIT
    cyc();
    cyc();
    RESETn = 1'b0; cyc(); RESETn = 1'b1;
    chk_reset("rst_wait");
    l0 = a_launches;
    repeat (CORE_LAT + 4) cyc();
    chk("stale_edge", {din_ready, key_valid, key_ready, iv_ready}, 4'b0011);
    chk("stale_launches", a_launches, l0);

    // recovery, and iv_load beating a same-cycle data accept
    key_in = NIST_KEY; key_load = 1'b1; cyc(); key_load = 1'b0;
    wait_cond(W_KV, "rec_key_valid");
    cyc();
    chk("rec_no_iv_launch", core_start, 0);
    iv_in = CTR2; iv_load = 1'b1; cyc(); iv_load = 1'b0;
    wait_cond(W_DR, "rec_have");
    din = DIN1; din_valid = 1'b1; iv_in = CTR1; iv_load = 1'b1; cyc(); iv_load = 1'b0;
    chk("iv_prio", last_acc, 0);
    chk("iv_prio_launch", {core_start, core_plaintext}, {1'b1, CTR1});
    send(DIN1, "rec_acc");
    chk("rec_dout", dout, DOUT1);
    repeat (3) cyc();
    chk("sb_drained", exp_q.size(), 0);

    // counter field wrap on the 8-bit instance
    b_key_in = NIST_KEY; b_key_load = 1'b1; cyc(); b_key_load = 1'b0;
    wait_cond(W_BKV, "b_key_valid");
    b_iv_in = CTR1; b_iv_load = 1'b1; cyc(); b_iv_load = 1'b0;
    chk("b_launch", {b_core_start, b_core_plaintext}, {1'b1, CTR1});
    b_din = DIN2; b_din_valid = 1'b1; n = 0;
    do begin cyc(); n++; end while (!b_acc && n < 200);
    b_din_valid = 1'b0;
    chk("b_acc", b_acc, 1);
    chk("b_dout", {b_dout_valid, b_dout}, {1'b1, DIN2 ^ ks_fn(NIST_KEY, CTR1)});
    chk("b_wrap_pt", {b_core_start, b_core_plaintext}, {1'b1, CTRW2});
    chk("b_wrap_set", b_ctr_wrap, 1);
    wait_cond(W_BDR, "b_have");
    chk("b_wrap_sticky", b_ctr_wrap, 1);
    b_iv_in = CTR1; b_iv_load = 1'b1; cyc(); b_iv_load = 1'b0;
    chk("b_wrap_clear", b_ctr_wrap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
